// File: rtl/scan_pkg.sv
// Shared definitions for the scan master: FSM state encoding, default chain
// length and the minimum run length before the halt line is honoured.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    TAIL,
    RUN_LO,
    RUN_HI
  } scan_state_t;

  // 24 core state bits + 15 bytes of memory + 16 key bits
  localparam int CHAIN_LEN_DEF = 160;
  localparam int HALT_MIN      = 4;

endpackage

// File: rtl/scan_shadow.sv
// Shadow image of the scan chain: byte-addressable write/readback port plus a
// one-bit-per-shift serial path that feeds the chain MSB first.
module scan_shadow #(
  parameter  int CHAIN_LEN = 160,
  localparam int NBYTES    = CHAIN_LEN / 8,
  localparam int AW        = $clog2(CHAIN_LEN / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          shift_en,
  input  logic          shift_bit,
  output logic          msb,
  output logic          next_msb
);

  logic [CHAIN_LEN-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (shift_en) begin
      bits <= {bits[CHAIN_LEN-2:0], shift_bit};
    end else if (wr_en && (32'(wr_addr) < NBYTES)) begin
      bits[8*wr_addr +: 8] <= wr_data;
    end
  end

  // Addresses past the last byte read as zero rather than aliasing
  assign rd_data  = (32'(rd_addr) < NBYTES) ? bits[8*rd_addr +: 8] : 8'h00;
  assign msb      = bits[CHAIN_LEN-1];
  assign next_msb = bits[CHAIN_LEN-2];

endmodule

// File: rtl/scan_master.sv
// Scan-chain master: swaps the shadow image with the core chain and, when
// SCAN_MASTER_RUN_EN is defined, clocks the core until halt or run_max cycles.
module scan_master
  import scan_pkg::*;
#(
  parameter  int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter  int CNT_W     = 8,
  localparam int AW        = $clog2(CHAIN_LEN / 8)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  input  logic             xchg_start,
  input  logic             run_start,
  input  logic [CNT_W-1:0] run_max,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] run_cycles,
  output logic             scan_clk_out,
  output logic             scan_en_n_out,
  output logic             proc_en_n_out,
  output logic             scan_data_out,
  input  logic             scan_data_in
);

  localparam int BW = $clog2(CHAIN_LEN);

  scan_state_t   state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          cap, cap_nxt;
  logic          clk_nxt, en_n_nxt, data_nxt, done_nxt;
  logic          shift_en, wr_ok, shadow_msb, shadow_next;

`ifdef SCAN_MASTER_RUN_EN
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt, run_cycles_nxt;
  logic             proc_n_nxt;
`else
  logic unused_run;
  assign unused_run    = ^{run_start, run_max};
  assign proc_en_n_out = 1'b1;
  assign run_cycles    = '0;
`endif

  scan_shadow #(.CHAIN_LEN(CHAIN_LEN)) u_shadow (
    .clk      (clk_in),
    .rst      (rst_in),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .shift_en (shift_en),
    .shift_bit(cap),
    .msb      (shadow_msb),
    .next_msb (shadow_next)
  );

  assign busy = (state != IDLE);

  // Pin outputs are computed one cycle ahead and registered so they never glitch
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cap_nxt     = cap;
    clk_nxt     = 1'b0;
    en_n_nxt    = scan_en_n_out;
    data_nxt    = scan_data_out;
    done_nxt    = 1'b0;
    shift_en    = 1'b0;
    wr_ok       = 1'b0;
`ifdef SCAN_MASTER_RUN_EN
    run_cnt_nxt    = run_cnt;
    run_cycles_nxt = run_cycles;
    proc_n_nxt     = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (xchg_start) begin
          state_nxt   = SHIFT_LO;
          bit_cnt_nxt = '0;
          en_n_nxt    = 1'b0;
          data_nxt    = shadow_msb;
`ifdef SCAN_MASTER_RUN_EN
        end else if (run_start) begin
          state_nxt   = RUN_LO;
          run_cnt_nxt = '0;
          proc_n_nxt  = 1'b0;
`endif
        end else begin
          wr_ok = wr_en;
        end
      end
      SHIFT_LO: begin
        cap_nxt   = scan_data_in;
        clk_nxt   = 1'b1;
        state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        shift_en = 1'b1;
        data_nxt = shadow_next;
        if (bit_cnt == BW'(CHAIN_LEN - 1)) begin
          state_nxt   = TAIL;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt   = SHIFT_LO;
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
      TAIL: begin
        if (bit_cnt == BW'(1)) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          en_n_nxt    = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + BW'(1);
        end
      end
`ifdef SCAN_MASTER_RUN_EN
      RUN_LO: begin
        if ((run_cnt == run_max) ||
            ((run_cnt >= CNT_W'(HALT_MIN)) && scan_data_in)) begin
          state_nxt      = IDLE;
          done_nxt       = 1'b1;
          run_cycles_nxt = run_cnt;
        end else begin
          state_nxt  = RUN_HI;
          clk_nxt    = 1'b1;
          proc_n_nxt = 1'b0;
        end
      end
      RUN_HI: begin
        proc_n_nxt  = 1'b0;
        state_nxt   = RUN_LO;
        run_cnt_nxt = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      cap           <= 1'b0;
      done          <= 1'b0;
      scan_clk_out  <= 1'b0;
      scan_en_n_out <= 1'b1;
      scan_data_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      cap           <= cap_nxt;
      done          <= done_nxt;
      scan_clk_out  <= clk_nxt;
      scan_en_n_out <= en_n_nxt;
      scan_data_out <= data_nxt;
    end
  end

`ifdef SCAN_MASTER_RUN_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_cnt       <= '0;
      run_cycles    <= '0;
      proc_en_n_out <= 1'b1;
    end else begin
      run_cnt       <= run_cnt_nxt;
      run_cycles    <= run_cycles_nxt;
      proc_en_n_out <= proc_n_nxt;
    end
  end
`endif

endmodule
